qarma128_tweak_walker: RTL and testbench
========================================

Name: qarma128_tweak_walker

Overview:
- Sequential tweak-schedule stepper for the QARMA-128 datapath.
- Loads a 128-bit tweak, then applies the per-cell tweak LFSR either forward (encryption-side) or inverse (decryption and reflector side), one step per accepted output beat.
- Each intermediate tweak is streamed out on a valid/ready interface.
- It runs the schedule in either direction, so the decryption core can rewind a forward-updated tweak without a second precomputed schedule.

Parameters:
- STEPS_W, 4, width of the step-count field; maximum steps per job is 2^STEPS_W-1.

Ports:
- clk  input  1  Clock; all state updates on the rising edge.
- rst  input  1  Synchronous, active-high reset.
- in_valid  input  1  Job request valid.
- in_ready  output  1  Walker idle and able to accept a job.
- in_tweak  input  128  Starting tweak.
- in_dir  input  1  0 = forward LFSR step, 1 = inverse LFSR step.
- in_steps  input  STEPS_W  Number of steps to apply (0 allowed).
- out_valid  output  1  out_tweak holds a valid stepped tweak.
- out_ready  input  1  Consumer accepts out_tweak.
- out_tweak  output  128  Tweak after k steps, with k = 1..in_steps.
- out_last  output  1  Qualifies the beat with k == in_steps.
- done  output  1  One-cycle pulse when a job completes.

Behaviour:
- Cell map: 16 cells of 8 bits, numbered MSB-first. Cell c = tweak[127-8c -: 8].
- Stepped cells: c in {0,1,3,4,8,11,13}. All other cells pass through unchanged.
- Forward cell step (x = 8-bit cell): y = {x[0]^x[2], x[7:1]}.
- Inverse cell step: y = {x[6:0], x[7]^x[1]}. Inverse(forward(x)) == x for all 256 values.
- One step updates all stepped cells in parallel, combinationally from the state register.
- Reset values: state IDLE, in_ready=1, out_valid=0, out_last=0, done=0, out_tweak=0, internal tweak and counter=0.
- IDLE state:
  - in_ready=1.
  - On in_valid with in_steps>0: latch dir and steps, load the register with the ONE-step result of in_tweak, set counter k=1, go to EMIT.
  - On in_valid with in_steps==0: go to FIN. No output beat is produced.
- EMIT state:
  - in_ready=0, out_valid=1, out_tweak = register, out_last = (k==steps).
  - out_tweak, out_last and out_valid stay stable while out_ready=0 (no drop, no change).
  - On out_ready with k<steps: register <= step(register), k <= k+1, stay in EMIT. The next beat is presented in the following cycle, so back-to-back throughput is 1 beat/cycle.
  - On out_ready with k==steps: go to FIN, out_valid=0 next cycle.
- FIN state: done=1 for exactly one cycle, then IDLE.
- Latency:
  - First out_valid asserts the cycle after in_valid&&in_ready.
  - done asserts the cycle after the last beat handshake.
  - For steps==0, done asserts the cycle after acceptance.
- in_valid while busy is ignored (in_ready=0). Inputs are sampled only on acceptance.
- out_ready while out_valid=0 has no effect.
- rst asserted in any state (including mid-job or stalled EMIT) returns all outputs to reset values next cycle. The partial job is discarded and done is not pulsed.
- Counter width is STEPS_W bits. in_steps = 2^STEPS_W-1 must complete without k wrapping.

Test Plan:
- Single forward step: in_tweak=128'h01010101_01010101_01010101_01010101, dir=0, steps=1, out_ready=1 -> one beat out_tweak=128'h80800180_80010101_80010180_01800101 with out_last=1, done the next cycle.
- Single inverse step: in_tweak = that result, dir=1, steps=1 -> out_tweak=128'h01010101_01010101_01010101_01010101. Also check a cell value 0x04 steps forward to 0x82.
- Round trip: random tweak, forward steps=15, take the final beat, feed it with dir=1, steps=15 -> final beat equals the original tweak; exactly 15 beats each way, out_last only on beat 15.
- Backpressure: steps=4, out_ready toggled pseudo-randomly -> out_tweak/out_last held stable while stalled, 4 beats in order matching the software model, a single done pulse, in_ready=0 throughout.
- Zero steps and busy rejection: steps=0 -> no out_valid, done one cycle after acceptance. A second in_valid during an active job -> not accepted, and the first job's results are unaffected.
- Reset mid-job: assert rst during a stalled EMIT with k=2 of 5 -> next cycle out_valid=0, in_ready=1, done=0; a new job then runs correctly from scratch.

Source files
------------

// File: rtl/qarma128_tweak_walker.sv
// qarma128_tweak_walker
// Steps a 128-bit QARMA-128 tweak through its per-cell LFSR schedule,
// forward (encryption side) or inverse (decryption / reflector side), and
// streams every intermediate tweak out on a valid/ready channel.
//
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   in_valid/in_ready        job handshake; in_ready is high only when idle
//   in_tweak, in_dir         starting tweak, 0 = forward, 1 = inverse
//   in_steps                 number of steps (0 = no beats, just done)
//   out_valid/out_ready      beat handshake
//   out_tweak, out_last      tweak after k steps, last flags k == in_steps
//   done                     one-cycle pulse after a job completes

// One 8-bit cell of the tweak LFSR, in either direction.
module qarma128_cell_step (
    input  logic [7:0] x,
    input  logic       dir,
    output logic [7:0] y
);
    // forward shifts right feeding x0^x2 in at the top; inverse undoes it
    assign y = dir ? {x[6:0], x[7] ^ x[1]} : {x[0] ^ x[2], x[7:1]};
endmodule

module qarma128_tweak_walker #(
    parameter int STEPS_W = 4
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [127:0]       in_tweak,
    input  logic               in_dir,
    input  logic [STEPS_W-1:0] in_steps,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [127:0]       out_tweak,
    output logic               out_last,
    output logic               done
);
    // bit c set = cell c (MSB-first) goes through the LFSR: cells 0,1,3,4,8,11,13
    localparam logic [15:0] STEP_MASK = 16'h291B;
    localparam logic [STEPS_W-1:0] ONE = {{(STEPS_W-1){1'b0}}, 1'b1};

    typedef enum logic [1:0] {IDLE, EMIT, FIN} state_t;

    state_t             state, state_nxt;
    logic [127:0]       tw;
    logic [STEPS_W-1:0] k, steps_r;
    logic               dir_r;
    logic               is_last;

    // A single step network is shared: in IDLE it pre-steps the incoming
    // tweak so the first beat is ready the cycle after acceptance; in EMIT
    // it advances the held register.
    logic [127:0] step_src, step_res;
    logic         step_dir;

    assign step_src = (state == IDLE) ? in_tweak : tw;
    assign step_dir = (state == IDLE) ? in_dir   : dir_r;

    genvar c;
    generate
        for (c = 0; c < 16; c++) begin : g_cell
            localparam int HI = 127 - 8*c;
            if (STEP_MASK[c]) begin : g_step
                qarma128_cell_step u_cell (
                    .x   (step_src[HI -: 8]),
                    .dir (step_dir),
                    .y   (step_res[HI -: 8])
                );
            end else begin : g_pass
                assign step_res[HI -: 8] = step_src[HI -: 8];
            end
        end
    endgenerate

    assign is_last   = (k == steps_r);
    assign out_tweak = tw;

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        out_last  = 1'b0;
        done      = 1'b0;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid)
                    state_nxt = (in_steps == '0) ? FIN : EMIT;
            end
            EMIT: begin
                out_valid = 1'b1;
                out_last  = is_last;
                if (out_ready && is_last)
                    state_nxt = FIN;
            end
            FIN: begin
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            tw      <= '0;
            k       <= '0;
            steps_r <= '0;
            dir_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: if (in_valid && in_steps != '0) begin
                    tw      <= step_res;
                    k       <= ONE;
                    steps_r <= in_steps;
                    dir_r   <= in_dir;
                end
                // k never passes steps_r, so a full-scale count cannot wrap
                EMIT: if (out_ready && !is_last) begin
                    tw <= step_res;
                    k  <= k + ONE;
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_qarma128_tweak_walker.sv
module tb_qarma128_tweak_walker;
    logic         clk;
    logic         rst;
    logic         in_valid;
    logic         in_ready;
    logic [127:0] in_tweak;
    logic         in_dir;
    logic [3:0]   in_steps;
    logic         out_valid;
    logic         out_ready;
    logic [127:0] out_tweak;
    logic         out_last;
    logic         done;

    int cmp_cnt = 0;
    int err_cnt = 0;

    logic [127:0] beat_tw   [0:31];
    logic         beat_last [0:31];
    int           nbeats, ndone, first_valid_cyc, done_cyc, timeout;

    qarma128_tweak_walker #(.STEPS_W(4)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_tweak  (in_tweak),
        .in_dir    (in_dir),
        .in_steps  (in_steps),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_tweak (out_tweak),
        .out_last  (out_last),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [127:0] model_step(input logic [127:0] t, input logic d);
        logic [127:0] r;
        logic [7:0]   x;
        r = t;
        for (int c = 0; c < 16; c++) begin
            if (c == 0 || c == 1 || c == 3 || c == 4 || c == 8 || c == 11 || c == 13) begin
                x = t[127-8*c -: 8];
                if (!d) r[127-8*c -: 8] = {x[0] ^ x[2], x[7:1]};
                else    r[127-8*c -: 8] = {x[6:0], x[7] ^ x[1]};
            end
        end
        return r;
    endfunction

    function automatic logic [127:0] rand128();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    // Launches one job with out_ready held high and records beats, done
    // timing and counts (cycle 1 = the cycle after acceptance).
    task automatic run_job(input logic [127:0] t, input logic d, input logic [3:0] s);
        nbeats = 0; ndone = 0; first_valid_cyc = -1; done_cyc = -1; timeout = 1;
        @(negedge clk);
        in_tweak = t; in_dir = d; in_steps = s; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        for (int cyc = 1; cyc <= 40; cyc++) begin
            if (out_valid) begin
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
                if (nbeats < 32) begin
                    beat_tw[nbeats]   = out_tweak;
                    beat_last[nbeats] = out_last;
                end
                nbeats++;
            end
            if (done) begin
                ndone++;
                done_cyc = cyc;
            end
            if (done_cyc > 0 && cyc >= done_cyc + 2) begin
                timeout = 0;
                break;
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_tweak = '0; in_dir = 1'b0; in_steps = '0; out_ready = 1'b0;
        repeat (2) @(negedge clk);
        cmp_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
        cmp_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
        cmp_cnt++; if (out_last !== 1'b0) begin err_cnt++; $display("FAIL reset_out_last got %b want 0", out_last); end
        cmp_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL reset_done got %b want 0", done); end
        cmp_cnt++; if (out_tweak !== 128'h0) begin err_cnt++; $display("FAIL reset_out_tweak got %h want 0", out_tweak); end
        rst = 1'b0;
    endtask

    task automatic test_single_fwd();
        run_job(128'h01010101_01010101_01010101_01010101, 1'b0, 4'd1);
        cmp_cnt++; if (timeout !== 0) begin err_cnt++; $display("FAIL fwd1_timeout got %0d want 0", timeout); end
        cmp_cnt++; if (nbeats !== 1) begin err_cnt++; $display("FAIL fwd1_beats got %0d want 1", nbeats); end
        cmp_cnt++; if (beat_tw[0] !== 128'h80800180_80010101_80010180_01800101) begin err_cnt++; $display("FAIL fwd1_tweak got %h want 80800180800101018001018001800101", beat_tw[0]); end
        cmp_cnt++; if (beat_last[0] !== 1'b1) begin err_cnt++; $display("FAIL fwd1_last got %b want 1", beat_last[0]); end
        cmp_cnt++; if (first_valid_cyc !== 1) begin err_cnt++; $display("FAIL fwd1_first_latency got %0d want 1", first_valid_cyc); end
        cmp_cnt++; if (done_cyc !== 2) begin err_cnt++; $display("FAIL fwd1_done_cycle got %0d want 2", done_cyc); end
        cmp_cnt++; if (ndone !== 1) begin err_cnt++; $display("FAIL fwd1_done_count got %0d want 1", ndone); end
    endtask

    task automatic test_single_inv();
        run_job(128'h80800180_80010101_80010180_01800101, 1'b1, 4'd1);
        cmp_cnt++; if (nbeats !== 1) begin err_cnt++; $display("FAIL inv1_beats got %0d want 1", nbeats); end
        cmp_cnt++; if (beat_tw[0] !== 128'h01010101_01010101_01010101_01010101) begin err_cnt++; $display("FAIL inv1_tweak got %h want 01 in every cell", beat_tw[0]); end
        cmp_cnt++; if (beat_last[0] !== 1'b1) begin err_cnt++; $display("FAIL inv1_last got %b want 1", beat_last[0]); end
        // cell 0 = 0x04 must step forward to 0x82
        run_job(128'h04000000_00000000_00000000_00000000, 1'b0, 4'd1);
        cmp_cnt++; if (beat_tw[0] !== 128'h82000000_00000000_00000000_00000000) begin err_cnt++; $display("FAIL cell04_tweak got %h want 82 followed by zeros", beat_tw[0]); end
    endtask

    task automatic test_round_trip();
        logic [127:0] orig, exp, fin;
        int bad_tw, bad_last;
        orig = rand128();
        run_job(orig, 1'b0, 4'd15);
        cmp_cnt++; if (nbeats !== 15) begin err_cnt++; $display("FAIL rt_fwd_beats got %0d want 15", nbeats); end
        exp = orig; bad_tw = 0; bad_last = 0;
        for (int i = 0; i < 15; i++) begin
            exp = model_step(exp, 1'b0);
            if (beat_tw[i] !== exp) bad_tw++;
            if (beat_last[i] !== (i == 14)) bad_last++;
        end
        cmp_cnt++; if (bad_tw !== 0) begin err_cnt++; $display("FAIL rt_fwd_sequence got %0d wrong beats want 0", bad_tw); end
        cmp_cnt++; if (bad_last !== 0) begin err_cnt++; $display("FAIL rt_fwd_last got %0d wrong flags want 0", bad_last); end
        cmp_cnt++; if (done_cyc !== 16) begin err_cnt++; $display("FAIL rt_fwd_done_cycle got %0d want 16", done_cyc); end
        fin = beat_tw[14];
        run_job(fin, 1'b1, 4'd15);
        cmp_cnt++; if (nbeats !== 15) begin err_cnt++; $display("FAIL rt_inv_beats got %0d want 15", nbeats); end
        cmp_cnt++; if (beat_tw[14] !== orig) begin err_cnt++; $display("FAIL rt_inv_final got %h want %h", beat_tw[14], orig); end
        bad_last = 0;
        for (int i = 0; i < 15; i++) if (beat_last[i] !== (i == 14)) bad_last++;
        cmp_cnt++; if (bad_last !== 0) begin err_cnt++; $display("FAIL rt_inv_last got %0d wrong flags want 0", bad_last); end
    endtask

    task automatic test_backpressure();
        logic [127:0] t, exp, held_tw;
        logic [15:0]  pat;
        logic         held_valid, held_last;
        int           dcyc, bad_tw, bad_last;
        t = rand128(); pat = 16'hB269; held_valid = 1'b0; held_tw = '0; held_last = 1'b0;
        nbeats = 0; ndone = 0; dcyc = -1;
        @(negedge clk);
        in_tweak = t; in_dir = 1'b0; in_steps = 4'd4; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_valid = 1'b0;
        for (int i = 0; i < 60; i++) begin
            if (held_valid) begin
                cmp_cnt++;
                if (out_valid !== 1'b1 || out_tweak !== held_tw || out_last !== held_last) begin
                    err_cnt++;
                    $display("FAIL bp_stall_hold got v=%b t=%h l=%b want v=1 t=%h l=%b", out_valid, out_tweak, out_last, held_tw, held_last);
                end
            end
            if (ndone == 0) begin
                cmp_cnt++; if (in_ready !== 1'b0) begin err_cnt++; $display("FAIL bp_in_ready_busy got %b want 0", in_ready); end
            end
            if (done) begin ndone++; dcyc = i; end
            out_ready = pat[i % 16];
            if (out_valid && out_ready) begin
                if (nbeats < 32) begin beat_tw[nbeats] = out_tweak; beat_last[nbeats] = out_last; end
                nbeats++;
            end
            held_valid = out_valid && !out_ready;
            held_tw = out_tweak; held_last = out_last;
            if (dcyc >= 0 && i >= dcyc + 2) break;
            @(negedge clk);
        end
        out_ready = 1'b0;
        cmp_cnt++; if (nbeats !== 4) begin err_cnt++; $display("FAIL bp_beats got %0d want 4", nbeats); end
        cmp_cnt++; if (ndone !== 1) begin err_cnt++; $display("FAIL bp_done_count got %0d want 1", ndone); end
        exp = t; bad_tw = 0; bad_last = 0;
        for (int i = 0; i < 4; i++) begin
            exp = model_step(exp, 1'b0);
            if (beat_tw[i] !== exp) bad_tw++;
            if (beat_last[i] !== (i == 3)) bad_last++;
        end
        cmp_cnt++; if (bad_tw !== 0) begin err_cnt++; $display("FAIL bp_sequence got %0d wrong beats want 0", bad_tw); end
        cmp_cnt++; if (bad_last !== 0) begin err_cnt++; $display("FAIL bp_last got %0d wrong flags want 0", bad_last); end
    endtask

    task automatic test_zero_and_busy();
        logic [127:0] t, exp;
        int bad_tw, dcyc, late_valid;
        run_job(rand128(), 1'b0, 4'd0);
        cmp_cnt++; if (nbeats !== 0) begin err_cnt++; $display("FAIL zero_beats got %0d want 0", nbeats); end
        cmp_cnt++; if (done_cyc !== 1) begin err_cnt++; $display("FAIL zero_done_cycle got %0d want 1", done_cyc); end
        cmp_cnt++; if (ndone !== 1) begin err_cnt++; $display("FAIL zero_done_count got %0d want 1", ndone); end

        // second request while the first job is stalled in EMIT
        t = rand128();
        @(negedge clk);
        in_tweak = t; in_dir = 1'b0; in_steps = 4'd3; in_valid = 1'b1; out_ready = 1'b0;
        @(negedge clk);
        in_tweak = ~t; in_dir = 1'b1; in_steps = 4'd7; in_valid = 1'b1;
        cmp_cnt++; if (in_ready !== 1'b0) begin err_cnt++; $display("FAIL busy_in_ready got %b want 0", in_ready); end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b1;
        nbeats = 0; ndone = 0; dcyc = -1; late_valid = 0;
        for (int i = 0; i < 30; i++) begin
            if (out_valid) begin
                if (dcyc >= 0) late_valid++;
                else if (nbeats < 32) beat_tw[nbeats] = out_tweak;
                if (dcyc < 0) nbeats++;
            end
            if (done) begin ndone++; dcyc = i; end
            if (dcyc >= 0 && i >= dcyc + 3) break;
            @(negedge clk);
        end
        cmp_cnt++; if (nbeats !== 3) begin err_cnt++; $display("FAIL busy_beats got %0d want 3", nbeats); end
        cmp_cnt++; if (ndone !== 1) begin err_cnt++; $display("FAIL busy_done_count got %0d want 1", ndone); end
        cmp_cnt++; if (late_valid !== 0) begin err_cnt++; $display("FAIL busy_ghost_job got %0d beats want 0", late_valid); end
        exp = t; bad_tw = 0;
        for (int i = 0; i < 3; i++) begin
            exp = model_step(exp, 1'b0);
            if (beat_tw[i] !== exp) bad_tw++;
        end
        cmp_cnt++; if (bad_tw !== 0) begin err_cnt++; $display("FAIL busy_sequence got %0d wrong beats want 0", bad_tw); end
    endtask

    task automatic test_reset_mid_job();
        logic [127:0] t, exp, t2;
        t = rand128();
        @(negedge clk);
        in_tweak = t; in_dir = 1'b1; in_steps = 4'd5; in_valid = 1'b1; out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;   // beat 1 handshakes at the next edge
        @(negedge clk);
        out_ready = 1'b0;  // stall on beat 2
        exp = model_step(model_step(t, 1'b1), 1'b1);
        cmp_cnt++; if (out_valid !== 1'b1 || out_tweak !== exp || out_last !== 1'b0) begin err_cnt++; $display("FAIL rst_pre_beat2 got v=%b t=%h l=%b want v=1 t=%h l=0", out_valid, out_tweak, out_last, exp); end
        rst = 1'b1;
        @(negedge clk);
        cmp_cnt++; if (out_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_mid_out_valid got %b want 0", out_valid); end
        cmp_cnt++; if (in_ready !== 1'b1) begin err_cnt++; $display("FAIL rst_mid_in_ready got %b want 1", in_ready); end
        cmp_cnt++; if (done !== 1'b0) begin err_cnt++; $display("FAIL rst_mid_done got %b want 0", done); end
        cmp_cnt++; if (out_tweak !== 128'h0 || out_last !== 1'b0) begin err_cnt++; $display("FAIL rst_mid_out_tweak got t=%h l=%b want 0", out_tweak, out_last); end
        rst = 1'b0;
        @(negedge clk);
        cmp_cnt++; if (done !== 1'b0 || out_valid !== 1'b0) begin err_cnt++; $display("FAIL rst_after_release got done=%b v=%b want 0", done, out_valid); end
        t2 = rand128();
        run_job(t2, 1'b0, 4'd5);
        exp = t2;
        for (int i = 0; i < 5; i++) exp = model_step(exp, 1'b0);
        cmp_cnt++; if (nbeats !== 5) begin err_cnt++; $display("FAIL rst_new_beats got %0d want 5", nbeats); end
        cmp_cnt++; if (beat_tw[4] !== exp) begin err_cnt++; $display("FAIL rst_new_final got %h want %h", beat_tw[4], exp); end
        cmp_cnt++; if (done_cyc !== 6) begin err_cnt++; $display("FAIL rst_new_done_cycle got %0d want 6", done_cyc); end
    endtask

    initial begin
        test_reset();
        test_single_fwd();
        test_single_inv();
        test_round_trip();
        test_backpressure();
        test_zero_and_busy();
        test_reset_mid_job();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_cnt, err_cnt);
        $finish;
    end
endmodule
